// File: rtl/decodificador_pkg.sv
// decodificador_pkg: state encoding, widths and the 3-to-7 one-hot decode function
package decodificador_pkg;
    localparam int ANCHO_COD = 3;
    localparam int ANCHO_SAL = 7;
    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        DIRECTO = 2'd1,
        BARRIDO = 2'd2
    } estado_t;
    // Shifting into an 8-bit word and dropping bit 0 maps code 0 to all zeros
    function automatic logic [ANCHO_SAL-1:0] decodifica(input logic [ANCHO_COD-1:0] cod);
        logic [ANCHO_SAL:0] oh;
        oh = {{ANCHO_SAL{1'b0}}, 1'b1} << cod;
        return oh[ANCHO_SAL:1];
    endfunction
endpackage

// File: rtl/decodificador_3a7_sec_contador.sv
// contador_paso: dwell counter for scan steps; fin_o pulses on the last enabled cycle of a step
module contador_paso
    import decodificador_pkg::*;
#(
    parameter int CICLOS_PASO = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic fin_o
);
    localparam int ANCHO = CICLOS_PASO > 1 ? $clog2(CICLOS_PASO) : 1;
    localparam logic [ANCHO-1:0] ULTIMO = ANCHO'(CICLOS_PASO - 1);
    logic [ANCHO-1:0] cuenta_q, cuenta_d;
    assign fin_o = en_i && cuenta_q == ULTIMO;
    always_comb cuenta_d = clr_i ? '0 : en_i ? (fin_o ? '0 : cuenta_q + ANCHO'(1)) : cuenta_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cuenta_q <= '0;
        else        cuenta_q <= cuenta_d;
    end
endmodule

// File: rtl/decodificador_3a7_sec.sv
// decodificador_3a7_sec: registered 3-to-7 one-hot decoder with an automatic 1..7 scan sequencer
module decodificador_3a7_sec
    import decodificador_pkg::*;
#(
    parameter int ANCHO_COD   = 3,
    parameter int ANCHO_SAL   = 7,
    parameter int CICLOS_PASO = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 habilita,
    input  logic                 valido_in,
    input  logic [ANCHO_COD-1:0] codigo_in,
    input  logic                 modo_barrido,
    output logic [ANCHO_SAL-1:0] salida,
    output logic [ANCHO_COD-1:0] codigo_out,
    output logic                 valido_out,
    output logic                 fin_barrido
);
    if (ANCHO_COD != 3 || ANCHO_SAL != 2**ANCHO_COD - 1 || CICLOS_PASO < 1) begin : g_param_invalido
        $error("decodificador_3a7_sec: unsupported parameter set");
    end

    estado_t              estado_q, estado_d;
    logic [ANCHO_COD-1:0] codigo_q, codigo_d;
    logic [ANCHO_SAL-1:0] salida_q;
    logic                 valido_q, valido_d, fin_q, fin_d;
    logic                 entra, en_paso, fin_paso;

    // Entry wins over everything else, including a wrap that would fall on the same edge
    assign entra   = habilita && modo_barrido && estado_q != BARRIDO;
    assign en_paso = habilita && modo_barrido && estado_q == BARRIDO;

    contador_paso #(.CICLOS_PASO(CICLOS_PASO)) u_contador (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_paso),
        .clr_i (entra),
        .fin_o (fin_paso)
    );

    always_comb begin
        estado_d = estado_q;
        if (habilita) begin
            case (estado_q)
                REPOSO, DIRECTO: estado_d = modo_barrido ? BARRIDO : valido_in ? DIRECTO : estado_q;
                BARRIDO:         estado_d = modo_barrido ? BARRIDO : REPOSO;
                default:         estado_d = modo_barrido ? BARRIDO : REPOSO;
            endcase
        end
    end

    always_comb begin
        codigo_d = codigo_q;
        valido_d = 1'b0;
        fin_d    = 1'b0;
        if (entra) begin
            codigo_d = ANCHO_COD'(1);
            valido_d = 1'b1;
        end else if (en_paso) begin
            codigo_d = fin_paso ? ((codigo_q == '1) ? ANCHO_COD'(1) : codigo_q + ANCHO_COD'(1)) : codigo_q;
            valido_d = fin_paso;
            fin_d    = fin_paso && codigo_q == '1;
        end else if (habilita && estado_q == BARRIDO) begin
            codigo_d = '0;
            valido_d = 1'b1;
        end else if (habilita && valido_in && (estado_q == REPOSO || estado_q == DIRECTO)) begin
            codigo_d = codigo_in;
            valido_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            codigo_q <= '0;
            salida_q <= '0;
            valido_q <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            codigo_q <= codigo_d;
            salida_q <= decodifica(codigo_d);
            valido_q <= valido_d;
            fin_q    <= fin_d;
        end
    end

    assign salida      = salida_q;
    assign codigo_out  = codigo_q;
    assign valido_out  = valido_q;
    assign fin_barrido = fin_q;
endmodule

// File: tb/tb_decodificador_3a7_sec.sv
// tb_decodificador_3a7_sec: vector table, scan/freeze/priority sequences and a random run against a behavioural model
module tb_decodificador_3a7_sec;
    localparam int PASO = 4;

    logic       clk, rst_n, habilita, valido_in, modo_barrido;
    logic [2:0] codigo_in, codigo_out;
    logic [6:0] salida;
    logic       valido_out, fin_barrido;

    int n_tests = 0;
    int n_fail  = 0;

    decodificador_3a7_sec #(.CICLOS_PASO(PASO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .habilita     (habilita),
        .valido_in    (valido_in),
        .codigo_in    (codigo_in),
        .modo_barrido (modo_barrido),
        .salida       (salida),
        .codigo_out   (codigo_out),
        .valido_out   (valido_out),
        .fin_barrido  (fin_barrido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // modo: 0 idle, 1 direct, 2 scan; shown = cycles the current scan code has been displayed
    typedef struct {
        int modo;
        int cod;
        int shown;
        bit vo;
        bit fin;
    } modelo_t;

    modelo_t mod;

    function automatic modelo_t siguiente(modelo_t m, bit hab, bit val, int cod, bit barr);
        modelo_t n = m;
        n.vo  = 0;
        n.fin = 0;
        if (!hab) return n;
        if (barr && m.modo != 2) begin
            n.modo = 2; n.cod = 1; n.shown = 1; n.vo = 1;
        end else if (barr) begin
            if (m.shown == PASO) begin
                n.cod = m.cod % 7 + 1; n.fin = (m.cod == 7); n.shown = 1; n.vo = 1;
            end else begin
                n.shown = m.shown + 1;
            end
        end else if (m.modo == 2) begin
            n.modo = 0; n.cod = 0; n.vo = 1;
        end else if (val) begin
            n.modo = 1; n.cod = cod; n.vo = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mod <= '{default: 0};
        else        mod <= siguiente(mod, habilita, valido_in, int'(codigo_in), modo_barrido);
    end

    // Reference 7-to-3 encoder for the loopback check
    function automatic int codifica(logic [6:0] s);
        int r = 0;
        for (int i = 0; i < 7; i++) if (s[i]) r = i + 1;
        return r;
    endfunction

    function automatic int onehot(int c);
        return c == 0 ? 0 : 1 << (c - 1);
    endfunction

    task automatic chk(input string nombre, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nombre, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic comparar_modelo();
        chk("model.salida", int'(salida), onehot(mod.cod));
        chk("model.codigo", int'(codigo_out), mod.cod);
        chk("model.valido", int'(valido_out), int'(mod.vo));
        chk("model.fin", int'(fin_barrido), int'(mod.fin));
        chk("loopback", codifica(salida), mod.cod);
        chk("one_hot", int'($countones(salida) <= 1), 1);
    endtask

    task automatic poner(input bit hab, input bit val, input int cod, input bit barr);
        habilita     = hab;
        valido_in    = val;
        codigo_in    = 3'(cod);
        modo_barrido = barr;
    endtask

    typedef struct {
        bit         hab;
        bit         val;
        int         cod;
        bit         barr;
        logic [6:0] e_sal;
        int         e_cod;
        bit         e_vo;
    } vec_t;

    vec_t tabla[14];

    initial begin
        int pulsos;
        tabla[0]  = '{1, 1, 1, 0, 7'b0000001, 1, 1};
        tabla[1]  = '{1, 1, 2, 0, 7'b0000010, 2, 1};
        tabla[2]  = '{1, 1, 3, 0, 7'b0000100, 3, 1};
        tabla[3]  = '{1, 1, 4, 0, 7'b0001000, 4, 1};
        tabla[4]  = '{1, 1, 5, 0, 7'b0010000, 5, 1};
        tabla[5]  = '{1, 1, 6, 0, 7'b0100000, 6, 1};
        tabla[6]  = '{1, 1, 7, 0, 7'b1000000, 7, 1};
        tabla[7]  = '{1, 1, 0, 0, 7'b0000000, 0, 1};
        tabla[8]  = '{1, 1, 6, 0, 7'b0100000, 6, 1};
        tabla[9]  = '{1, 0, 3, 0, 7'b0100000, 6, 0};
        tabla[10] = '{0, 1, 2, 0, 7'b0100000, 6, 0};
        tabla[11] = '{0, 0, 2, 0, 7'b0100000, 6, 0};
        tabla[12] = '{1, 1, 2, 0, 7'b0000010, 2, 1};
        tabla[13] = '{1, 1, 2, 0, 7'b0000010, 2, 1};

        rst_n = 1'b0;
        poner(1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.salida", int'(salida), 0);
        chk("reset.codigo", int'(codigo_out), 0);
        chk("reset.valido", int'(valido_out), 0);
        chk("reset.fin", int'(fin_barrido), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            poner(tabla[i].hab, tabla[i].val, tabla[i].cod, tabla[i].barr);
            cyc();
            chk($sformatf("vec%0d.salida", i), int'(salida), int'(tabla[i].e_sal));
            chk($sformatf("vec%0d.codigo", i), int'(codigo_out), tabla[i].e_cod);
            chk($sformatf("vec%0d.valido", i), int'(valido_out), int'(tabla[i].e_vo));
            comparar_modelo();
        end

        // Asynchronous reset mid-cycle, no clock edge in between
        poner(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.salida", int'(salida), 0);
        chk("async_rst.codigo", int'(codigo_out), 0);
        chk("async_rst.valido", int'(valido_out), 0);
        #1 rst_n = 1'b1;

        // Scan laps: fin at 29 and 57 relative to entry
        pulsos = 0;
        poner(1, 0, 0, 1);
        for (int i = 1; i <= 60; i++) begin
            cyc();
            chk($sformatf("scan%0d.salida", i), int'(salida), onehot(((i - 1) / PASO) % 7 + 1));
            chk($sformatf("scan%0d.fin", i), int'(fin_barrido), int'(i == 29 || i == 57));
            chk($sformatf("scan%0d.valido", i), int'(valido_out), int'((i - 1) % PASO == 0));
            if (i <= 28 && valido_out) pulsos++;
            comparar_modelo();
        end
        chk("scan.pulses_per_lap", pulsos, 7);

        poner(1, 0, 0, 0);
        cyc();
        chk("scan_exit.salida", int'(salida), 0);
        chk("scan_exit.codigo", int'(codigo_out), 0);
        chk("scan_exit.valido", int'(valido_out), 1);

        // Scan beats a simultaneous valid code
        poner(1, 1, 5, 1);
        cyc();
        chk("priority.salida", int'(salida), 7'b0000001);
        chk("priority.codigo", int'(codigo_out), 1);
        poner(1, 0, 0, 1);
        for (int i = 2; i <= 10; i++) begin
            cyc();
            comparar_modelo();
        end

        // Freeze at step 3, cycle 2, then resume with two cycles remaining
        poner(0, 1, 6, 1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("freeze.salida", int'(salida), 7'b0000100);
            chk("freeze.valido", int'(valido_out), 0);
            chk("freeze.fin", int'(fin_barrido), 0);
        end
        poner(1, 0, 0, 1);
        cyc();
        chk("resume1.salida", int'(salida), 7'b0000100);
        cyc();
        chk("resume2.salida", int'(salida), 7'b0000100);
        cyc();
        chk("resume3.salida", int'(salida), 7'b0001000);
        chk("resume3.valido", int'(valido_out), 1);

        // Randomised run against the model
        poner(1, 0, 0, 0);
        cyc();
        for (int i = 0; i < 500; i++) begin
            habilita  = $urandom_range(0, 9) != 0;
            valido_in = $urandom_range(0, 1) != 0;
            codigo_in = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) modo_barrido = ~modo_barrido;
            cyc();
            comparar_modelo();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
